// File: rtl/decode_pkg.sv
// Shared decode constants: opcodes, itype bit positions, immediate formats.
// Used by decode_stage and decode_rf.
package decode_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam int ITYPE_R   = 0;
  localparam int ITYPE_I   = 1;
  localparam int ITYPE_S   = 2;
  localparam int ITYPE_U   = 3;
  localparam int ITYPE_ILL = 4;
  localparam int ITYPE_W   = 5;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_U,
    FMT_ILL
  } imm_fmt_e;

  function automatic imm_fmt_e classify(input logic [6:0] op);
    case (op)
      OP_R:                     return FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_LUI, OP_AUIPC:         return FMT_U;
      default:                  return FMT_ILL;
    endcase
  endfunction

  function automatic logic [31:0] imm32(input imm_fmt_e fmt, input logic [31:0] ir);
    case (fmt)
      FMT_I:   return {{20{ir[31]}}, ir[31:20]};
      FMT_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      FMT_U:   return {ir[31:12], 12'b0};
      default: return 32'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_rf.sv
// Register file for the decode stage: two async read ports, one sync write port.
// Index 0 always reads zero and ignores writes.
module decode_rf
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rd1_addr_i,
  output logic [XLEN-1:0] rd1_data_o,
  input  logic [AW-1:0]   rd2_addr_i,
  output logic [XLEN-1:0] rd2_data_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] r_regs [NREGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      r_regs[wa_i] <= wd_i;
    end
  end

  assign rd1_data_o = (rd1_addr_i == '0) ? '0 : r_regs[rd1_addr_i];
  assign rd2_data_o = (rd2_addr_i == '0) ? '0 : r_regs[rd2_addr_i];

endmodule

// File: rtl/decode_stage.sv
// Single-cycle instruction decode with registered output and valid/ready flow control.
// Optional macro DECODE_BYPASS_EN forwards a same-cycle writeback into the operands.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     ir_i,
  input  logic            ir_valid_i,
  output logic            ir_ready_o,
  input  logic            wb_en_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] ra_o,
  output logic [XLEN-1:0] rb_o,
  output logic [XLEN-1:0] imm_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      func3_o,
  output logic [6:0]      func7_o,
  output logic [4:0]      itype_o,
  output logic            valid_o,
  input  logic            ready_i
);

  imm_fmt_e          w_fmt;
  logic [AW-1:0]     w_rs1;
  logic [AW-1:0]     w_rs2;
  logic [XLEN-1:0]   w_rf_rd1;
  logic [XLEN-1:0]   w_rf_rd2;
  logic [XLEN-1:0]   w_rs1_val;
  logic [XLEN-1:0]   w_rs2_val;
  logic [31:0]       w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic [ITYPE_W-1:0] w_itype;
  logic              w_use_rs1;
  logic              w_use_rs2;
  logic              w_accept;

  assign w_fmt   = classify(ir_i[6:0]);
  assign w_rs1   = ir_i[15 +: AW];
  assign w_rs2   = ir_i[20 +: AW];
  assign w_imm32 = imm32(w_fmt, ir_i);

  decode_rf #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_rf (
    .clk        (clk),
    .reset      (reset),
    .rd1_addr_i (w_rs1),
    .rd1_data_o (w_rf_rd1),
    .rd2_addr_i (w_rs2),
    .rd2_data_o (w_rf_rd2),
    .we_i       (wb_en_i),
    .wa_i       (wb_addr_i),
    .wd_i       (wb_data_i)
  );

`ifdef DECODE_BYPASS_EN
  assign w_rs1_val = (wb_en_i && (wb_addr_i == w_rs1) && (w_rs1 != '0)) ? wb_data_i : w_rf_rd1;
  assign w_rs2_val = (wb_en_i && (wb_addr_i == w_rs2) && (w_rs2 != '0)) ? wb_data_i : w_rf_rd2;
`else
  assign w_rs1_val = w_rf_rd1;
  assign w_rs2_val = w_rf_rd2;
`endif

  generate
    if (XLEN > 32) begin : g_imm_ext
      assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
    end else if (XLEN == 32) begin : g_imm_eq
      assign w_imm = w_imm32;
    end else begin : g_imm_trunc
      assign w_imm = w_imm32[XLEN-1:0];
    end
  endgenerate

  always_comb begin
    w_itype = '0;
    case (w_fmt)
      FMT_R:   w_itype[ITYPE_R]   = 1'b1;
      FMT_I:   w_itype[ITYPE_I]   = 1'b1;
      FMT_S:   w_itype[ITYPE_S]   = 1'b1;
      FMT_U:   w_itype[ITYPE_U]   = 1'b1;
      default: w_itype[ITYPE_ILL] = 1'b1;
    endcase
  end

  assign w_use_rs1  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S);
  assign w_use_rs2  = (w_fmt == FMT_R) || (w_fmt == FMT_S);
  assign ir_ready_o = !valid_o || ready_i;
  assign w_accept   = ir_valid_i && ir_ready_o;

  // Output register holds its contents while stalled; only valid_o drops on drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o <= 1'b0;
      ra_o    <= '0;
      rb_o    <= '0;
      imm_o   <= '0;
      rd_o    <= '0;
      func3_o <= '0;
      func7_o <= '0;
      itype_o <= '0;
    end else if (w_accept) begin
      valid_o <= 1'b1;
      ra_o    <= w_use_rs1 ? w_rs1_val : '0;
      rb_o    <= w_use_rs2 ? w_rs2_val : '0;
      imm_o   <= w_imm;
      rd_o    <= ir_i[11:7];
      func3_o <= ir_i[14:12];
      func7_o <= ir_i[31:25];
      itype_o <= w_itype;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed vectors, corner sequences and random traffic
// checked against a transaction-level model of the decode rules.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_i;
  logic        ir_valid_i;
  logic        ir_ready_o;
  logic        wb_en_i;
  logic [4:0]  wb_addr_i;
  logic [31:0] wb_data_i;
  logic [31:0] ra_o, rb_o, imm_o;
  logic [4:0]  rd_o;
  logic [2:0]  func3_o;
  logic [6:0]  func7_o;
  logic [4:0]  itype_o;
  logic        valid_o;
  logic        ready_i;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .ir_i       (ir_i),
    .ir_valid_i (ir_valid_i),
    .ir_ready_o (ir_ready_o),
    .wb_en_i    (wb_en_i),
    .wb_addr_i  (wb_addr_i),
    .wb_data_i  (wb_data_i),
    .ra_o       (ra_o),
    .rb_o       (rb_o),
    .imm_o      (imm_o),
    .rd_o       (rd_o),
    .func3_o    (func3_o),
    .func7_o    (func7_o),
    .itype_o    (itype_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i)
  );

`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] m_rf [32];
  logic        m_valid;
  logic [31:0] m_ra, m_rb, m_imm;
  logic [4:0]  m_rd, m_itype;
  logic [2:0]  m_f3;
  logic [6:0]  m_f7;

  typedef struct {
    logic [31:0] ir;
    logic [4:0]  itype;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] src_val(input logic [4:0] s);
    if (s == 5'd0) return 32'd0;
    if (BYP && wb_en_i && wb_addr_i == s) return wb_data_i;
    return m_rf[s];
  endfunction

  task automatic model_capture();
    int kind;
    int v;
    case (ir_i[6:0])
      7'h33:               kind = 0;
      7'h13, 7'h03, 7'h67: kind = 1;
      7'h23:               kind = 2;
      7'h37, 7'h17:        kind = 3;
      default:             kind = 4;
    endcase
    m_itype = 5'b00001 << kind;
    case (kind)
      1: begin v = int'(ir_i[31:20]); if (v >= 2048) v -= 4096; m_imm = 32'(v); end
      2: begin v = int'({ir_i[31:25], ir_i[11:7]}); if (v >= 2048) v -= 4096; m_imm = 32'(v); end
      3: m_imm = ir_i & 32'hFFFF_F000;
      default: m_imm = 32'd0;
    endcase
    m_ra    = (kind <= 2) ? src_val(ir_i[19:15]) : 32'd0;
    m_rb    = (kind == 0 || kind == 2) ? src_val(ir_i[24:20]) : 32'd0;
    m_rd    = ir_i[11:7];
    m_f3    = ir_i[14:12];
    m_f7    = ir_i[31:25];
    m_valid = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ir, input logic rdy,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
    ir_valid_i = v;
    ir_i       = ir;
    ready_i    = rdy;
    wb_en_i    = we;
    wb_addr_i  = wa;
    wb_data_i  = wd;
  endtask

  // One clock: check handshake, advance the model, then compare registered outputs.
  task automatic step();
    logic acc;
    #1;
    chk("ir_ready", ir_ready_o, !m_valid || ready_i);
    acc = ir_valid_i && (!m_valid || ready_i);
    if (acc) model_capture();
    else if (ready_i) m_valid = 1'b0;
    if (wb_en_i && wb_addr_i != 5'd0) m_rf[wb_addr_i] = wb_data_i;
    @(posedge clk);
    #1;
    chk("valid", valid_o, m_valid);
    if (m_valid) begin
      chk("ra", ra_o, m_ra);
      chk("rb", rb_o, m_rb);
      chk("imm", imm_o, m_imm);
      chk("rd", rd_o, m_rd);
      chk("func3", func3_o, m_f3);
      chk("func7", func7_o, m_f7);
      chk("itype", itype_o, m_itype);
    end
  endtask

  initial begin
    logic [6:0] ops [9];
    logic [31:0] held_ra;
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h37, 7'h17, 7'h7F, 7'h6F};

    vecs[0] = '{32'h006283B3, 5'b00001, 32'h00000000};
    vecs[1] = '{32'hFFF00093, 5'b00010, 32'hFFFFFFFF};
    vecs[2] = '{32'hFE21AE23, 5'b00100, 32'hFFFFFFFC};
    vecs[3] = '{32'h0000007F, 5'b10000, 32'h00000000};
    vecs[4] = '{32'h12345037, 5'b01000, 32'h12345000};
    vecs[5] = '{32'hFFFFF017, 5'b01000, 32'hFFFFF000};
    vecs[6] = '{32'h00412083, 5'b00010, 32'h00000004};
    vecs[7] = '{32'h800080E7, 5'b00010, 32'hFFFFF800};
    vecs[8] = '{32'h0000006F, 5'b10000, 32'h00000000};
    vecs[9] = '{32'h00B50123, 5'b00100, 32'h00000002};

    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_valid = 1'b0;
    reset = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0);

    #3;
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_itype", itype_o, 5'd0);
    chk("rst_ra", ra_o, 32'd0);
    chk("rst_imm", imm_o, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Writeback then R-type read of the written registers
    drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd5, 32'h12345678); step();
    drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd6, 32'h00000010); step();
    drive(1'b1, 32'h006283B3, 1'b1, 1'b0, 5'd0, 32'd0); step();
    chk("add_valid", valid_o, 1'b1);
    chk("add_ra", ra_o, 32'h12345678);
    chk("add_rb", rb_o, 32'h00000010);
    chk("add_itype", itype_o, 5'b00001);
    chk("add_rd", rd_o, 5'd7);

    // Writeback to a source register in the accept cycle
    drive(1'b1, 32'h006283B3, 1'b1, 1'b1, 5'd5, 32'hAAAA0000); step();
    chk("same_cycle_wb_ra", ra_o, BYP ? 32'hAAAA0000 : 32'h12345678);
    drive(1'b1, 32'h006283B3, 1'b1, 1'b0, 5'd0, 32'd0); step();
    chk("after_wb_ra", ra_o, 32'hAAAA0000);

    // Stall three cycles, then back-to-back accepts
    drive(1'b1, 32'hFE21AE23, 1'b1, 1'b0, 5'd0, 32'd0); step();
    held_ra = ra_o;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hFFF00093, 1'b0, 1'b0, 5'd0, 32'd0); step();
      chk("stall_ir_ready", ir_ready_o, 1'b0);
      chk("stall_imm", imm_o, 32'hFFFFFFFC);
      chk("stall_ra", ra_o, held_ra);
      chk("stall_itype", itype_o, 5'b00100);
    end
    drive(1'b1, 32'hFFF00093, 1'b1, 1'b0, 5'd0, 32'd0); step();
    chk("resume_valid", valid_o, 1'b1);
    chk("resume_imm", imm_o, 32'hFFFFFFFF);
    drive(1'b1, 32'h006283B3, 1'b1, 1'b0, 5'd0, 32'd0); step();
    chk("b2b_valid", valid_o, 1'b1);
    chk("b2b_itype", itype_o, 5'b00001);

    // x0 stays zero after a write attempt
    drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF); step();
    drive(1'b1, 32'hFFF00093, 1'b1, 1'b0, 5'd0, 32'd0); step();
    chk("x0_ra", ra_o, 32'd0);
    chk("x0_itype", itype_o, 5'b00010);

    for (int i = 0; i < 10; i++) begin
      drive(1'b1, vecs[i].ir, 1'b1, 1'b0, 5'd0, 32'd0);
      step();
      chk($sformatf("vec%0d_itype", i), itype_o, vecs[i].itype);
      chk($sformatf("vec%0d_imm", i), imm_o, vecs[i].imm);
    end

    // Reset while valid_o=1, with a writeback pending that must be dropped
    drive(1'b0, 32'd0, 1'b0, 1'b1, 5'd9, 32'hDEADBEEF);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", valid_o, 1'b0);
    chk("mid_rst_ra", ra_o, 32'd0);
    chk("mid_rst_imm", imm_o, 32'd0);
    chk("mid_rst_itype", itype_o, 5'd0);
    chk("mid_rst_rd", rd_o, 5'd0);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(1'b1, 32'h009283B3, 1'b1, 1'b0, 5'd0, 32'd0); step();
    chk("post_rst_valid", valid_o, 1'b1);
    chk("post_rst_ra", ra_o, 32'd0);
    chk("post_rst_rb", rb_o, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ir;
      ir = {$urandom_range(0, 32'h1FF_FFFF), 7'd0};
      ir[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 9) == 0) ir[6:0] = 7'($urandom);
      drive($urandom_range(0, 3) != 0, ir, $urandom_range(0, 9) < 7,
            $urandom_range(0, 1) == 1, 5'($urandom), $urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
